// File: rtl/fetch_exec_sequencer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_exec_sequencer_pkg                                                   |
// | Opcode, state and ACC operation encodings shared by the sequencer.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fetch_exec_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_MEM_WR = 3'd3,
        ST_HALT   = 3'd4
    } state_e;

    localparam logic [3:0] c_op_nop = 4'h0;
    localparam logic [3:0] c_op_lda = 4'h1;
    localparam logic [3:0] c_op_sta = 4'h2;
    localparam logic [3:0] c_op_add = 4'h3;
    localparam logic [3:0] c_op_sub = 4'h4;
    localparam logic [3:0] c_op_and = 4'h5;
    localparam logic [3:0] c_op_jmp = 4'h6;
    localparam logic [3:0] c_op_jz  = 4'h7;
    localparam logic [3:0] c_op_hlt = 4'h8;

    localparam logic [1:0] c_acc_pass = 2'b00;
    localparam logic [1:0] c_acc_add  = 2'b01;
    localparam logic [1:0] c_acc_sub  = 2'b10;
    localparam logic [1:0] c_acc_and  = 2'b11;

    function automatic logic [1:0] acc_op_of(input logic [3:0] opcode);
        logic [1:0] op;
        case (opcode)
            c_op_add: op = c_acc_add;
            c_op_sub: op = c_acc_sub;
            c_op_and: op = c_acc_and;
            default:  op = c_acc_pass;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_exec_sequencer_bus_wait_timer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_exec_sequencer_bus_wait_timer                                        |
// | Counts memory wait cycles; expired_o marks the last allowed wait cycle.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_exec_sequencer_bus_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic count_i,
    output logic expired_o
);

    localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(WAIT_MAX - 1);

    logic [CNT_W-1:0] r_count_q;
    logic [CNT_W-1:0] w_count_d;

    // Saturates at the last wait cycle so expired_o stays stable until cleared
    always_comb begin
        w_count_d = r_count_q;
        if (clear_i) begin
            w_count_d = '0;
        end else if (count_i && (r_count_q != c_last)) begin
            w_count_d = r_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count_q <= '0;
        end else begin
            r_count_q <= w_count_d;
        end
    end

    assign expired_o = (r_count_q == c_last);

endmodule
`default_nettype wire

// File: rtl/fetch_exec_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_exec_sequencer                                                       |
// | Fetch/decode/execute control FSM arbitrating the single memory port.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_exec_sequencer #(
    parameter int ADDR_W   = 12,
    parameter int WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       REST,
    input  logic [3:0] OPCODE,
    input  logic       ACC_ZERO,
    input  logic       MEM_RDY,
    output logic       PC_EN,
    output logic       PC_LOAD,
    output logic       IR_LOAD,
    output logic       ADDR_SEL,
    output logic       MEM_RD,
    output logic       MEM_WR,
    output logic       ACC_LOAD,
    output logic [1:0] ACC_OP,
    output logic       HALTED,
    output logic       BUS_ERR,
    output logic       ILL_OP,
    output logic [2:0] STATE
);

    import fetch_exec_sequencer_pkg::*;

    state_e     r_state_q;
    state_e     w_state_d;
    logic [1:0] r_acc_op_q;
    logic [1:0] w_acc_op_d;
    logic       r_bus_err_q;
    logic       r_ill_op_q;

    logic w_pc_en;
    logic w_pc_load;
    logic w_ir_load;
    logic w_addr_sel;
    logic w_mem_rd;
    logic w_mem_wr;
    logic w_acc_load;
    logic w_set_ill_op;
    logic w_access;
    logic w_expired;
    logic w_timeout;
    logic w_timer_clear;
    logic w_timer_count;

    assign w_access = (r_state_q == ST_FETCH) || (r_state_q == ST_MEM_RD) ||
                      (r_state_q == ST_MEM_WR);
    // A ready arriving in the last allowed cycle completes the access instead
    assign w_timeout     = w_access && w_expired && !MEM_RDY;
    assign w_timer_clear = (w_state_d != r_state_q);
    assign w_timer_count = w_access && !MEM_RDY;

    fetch_exec_sequencer_bus_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (REST),
        .clear_i   (w_timer_clear),
        .count_i   (w_timer_count),
        .expired_o (w_expired)
    );

    always_comb begin
        w_state_d    = r_state_q;
        w_acc_op_d   = r_acc_op_q;
        w_pc_en      = 1'b0;
        w_pc_load    = 1'b0;
        w_ir_load    = 1'b0;
        w_addr_sel   = 1'b0;
        w_mem_rd     = 1'b0;
        w_mem_wr     = 1'b0;
        w_acc_load   = 1'b0;
        w_set_ill_op = 1'b0;
        case (r_state_q)
            ST_FETCH: begin
                if (MEM_RDY) begin
                    w_mem_rd  = 1'b1;
                    w_ir_load = 1'b1;
                    w_pc_en   = 1'b1;
                    w_state_d = ST_DECODE;
                end else if (w_expired) begin
                    w_state_d = ST_HALT;
                end else begin
                    w_mem_rd = 1'b1;
                end
            end
            ST_DECODE: begin
                w_acc_op_d = acc_op_of(OPCODE);
                case (OPCODE)
                    c_op_nop: w_state_d = ST_FETCH;
                    c_op_jmp: begin
                        w_pc_load = 1'b1;
                        w_state_d = ST_FETCH;
                    end
                    c_op_jz: begin
                        w_pc_load = ACC_ZERO;
                        w_state_d = ST_FETCH;
                    end
                    c_op_lda, c_op_add, c_op_sub, c_op_and: w_state_d = ST_MEM_RD;
                    c_op_sta: w_state_d = ST_MEM_WR;
                    c_op_hlt: w_state_d = ST_HALT;
                    default: begin
                        w_set_ill_op = 1'b1;
                        w_state_d    = ST_HALT;
                    end
                endcase
            end
            ST_MEM_RD: begin
                w_addr_sel = 1'b1;
                if (MEM_RDY) begin
                    w_mem_rd   = 1'b1;
                    w_acc_load = 1'b1;
                    w_state_d  = ST_FETCH;
                end else if (w_expired) begin
                    w_state_d = ST_HALT;
                end else begin
                    w_mem_rd = 1'b1;
                end
            end
            ST_MEM_WR: begin
                w_addr_sel = 1'b1;
                if (MEM_RDY) begin
                    w_mem_wr  = 1'b1;
                    w_state_d = ST_FETCH;
                end else if (w_expired) begin
                    w_state_d = ST_HALT;
                end else begin
                    w_mem_wr = 1'b1;
                end
            end
            ST_HALT: w_state_d = ST_HALT;
            default: w_state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (REST) begin
            r_state_q   <= ST_FETCH;
            r_acc_op_q  <= c_acc_pass;
            r_bus_err_q <= 1'b0;
            r_ill_op_q  <= 1'b0;
        end else begin
            r_state_q  <= w_state_d;
            r_acc_op_q <= w_acc_op_d;
            if (w_timeout) begin
                r_bus_err_q <= 1'b1;
            end
            if (w_set_ill_op) begin
                r_ill_op_q <= 1'b1;
            end
        end
    end

    // Reset aborts any in-flight access immediately, not at the next edge
    assign PC_EN    = w_pc_en    && !REST;
    assign PC_LOAD  = w_pc_load  && !REST;
    assign IR_LOAD  = w_ir_load  && !REST;
    assign MEM_RD   = w_mem_rd   && !REST;
    assign MEM_WR   = w_mem_wr   && !REST;
    assign ACC_LOAD = w_acc_load && !REST;
    assign ADDR_SEL = w_addr_sel;
    assign ACC_OP   = r_acc_op_q;
    assign HALTED   = (r_state_q == ST_HALT);
    assign BUS_ERR  = r_bus_err_q;
    assign ILL_OP   = r_ill_op_q;

    // The state readout rides the address-width debug bus; too narrow a bus cannot carry it
    generate
        if (ADDR_W >= 3) begin : g_state_dbg
            assign STATE = r_state_q;
        end else begin : g_state_tie
            assign STATE = 3'b000;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_fetch_exec_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_exec_sequencer                                                    |
// | Instruction-level reference model driving directed and random programs.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fetch_exec_sequencer;

    localparam int WAIT_MAX = 15;
    localparam int NEVER    = 1000;
    localparam logic [2:0] S_FETCH = 3'd0, S_DECODE = 3'd1, S_RD = 3'd2, S_WR = 3'd3, S_HALT = 3'd4;
    localparam logic [3:0] OP_NOP = 4'h0, OP_LDA = 4'h1, OP_STA = 4'h2, OP_ADD = 4'h3,
                           OP_SUB = 4'h4, OP_AND = 4'h5, OP_JMP = 4'h6, OP_JZ = 4'h7, OP_HLT = 4'h8;

    logic       clk = 1'b0;
    logic       REST = 1'b1;
    logic [3:0] OPCODE = 4'h0;
    logic       ACC_ZERO = 1'b0;
    logic       MEM_RDY = 1'b0;
    logic       PC_EN, PC_LOAD, IR_LOAD, ADDR_SEL, MEM_RD, MEM_WR, ACC_LOAD;
    logic [1:0] ACC_OP;
    logic       HALTED, BUS_ERR, ILL_OP;
    logic [2:0] STATE;

    fetch_exec_sequencer #(.ADDR_W(12), .WAIT_MAX(WAIT_MAX)) dut (
        .clk(clk), .REST(REST), .OPCODE(OPCODE), .ACC_ZERO(ACC_ZERO), .MEM_RDY(MEM_RDY),
        .PC_EN(PC_EN), .PC_LOAD(PC_LOAD), .IR_LOAD(IR_LOAD), .ADDR_SEL(ADDR_SEL),
        .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .ACC_LOAD(ACC_LOAD), .ACC_OP(ACC_OP),
        .HALTED(HALTED), .BUS_ERR(BUS_ERR), .ILL_OP(ILL_OP), .STATE(STATE)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int base    = 0;
    int obs_rd, obs_wr, obs_irl, obs_pcen, obs_pcl, obs_accl, halt_at, berr_at;

    // Expected outputs for the cycle about to be driven
    logic       e_pc_en, e_pc_load, e_ir_load, e_addr_sel, e_mem_rd, e_mem_wr, e_acc_load, e_halted;
    logic [1:0] e_acc_op;
    logic [2:0] e_state;
    bit         chk_addr, chk_status;
    // Architectural state of the model
    bit         m_bus_err = 1'b0;
    bit         m_ill_op  = 1'b0;
    logic [1:0] m_acc_op  = 2'b00;
    logic [3:0] cur_opc   = 4'h0;

    function automatic logic rb();
        rb = 1'($urandom_range(1, 0));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic clr_exp();
        e_pc_en = 0; e_pc_load = 0; e_ir_load = 0; e_addr_sel = 0;
        e_mem_rd = 0; e_mem_wr = 0; e_acc_load = 0; e_acc_op = 0;
        e_halted = 0; e_state = S_FETCH; chk_addr = 0; chk_status = 1;
    endtask

    task automatic obs_clear();
        obs_rd = 0; obs_wr = 0; obs_irl = 0; obs_pcen = 0; obs_pcl = 0; obs_accl = 0;
        halt_at = -1; berr_at = -1; base = cyc;
    endtask

    // One clock: drive just after the edge, compare on the falling edge
    task automatic step(input logic rest, input logic rdy, input logic az);
        @(posedge clk);
        #1;
        REST = rest; MEM_RDY = rdy; ACC_ZERO = az; OPCODE = cur_opc;
        cyc++;
        @(negedge clk);
        chk("PC_EN", {31'd0, PC_EN}, {31'd0, e_pc_en});
        chk("PC_LOAD", {31'd0, PC_LOAD}, {31'd0, e_pc_load});
        chk("IR_LOAD", {31'd0, IR_LOAD}, {31'd0, e_ir_load});
        chk("MEM_RD", {31'd0, MEM_RD}, {31'd0, e_mem_rd});
        chk("MEM_WR", {31'd0, MEM_WR}, {31'd0, e_mem_wr});
        chk("ACC_LOAD", {31'd0, ACC_LOAD}, {31'd0, e_acc_load});
        if (chk_addr) chk("ADDR_SEL", {31'd0, ADDR_SEL}, {31'd0, e_addr_sel});
        if (e_acc_load) chk("ACC_OP", {30'd0, ACC_OP}, {30'd0, e_acc_op});
        if (chk_status) begin
            chk("STATE", {29'd0, STATE}, {29'd0, e_state});
            chk("HALTED", {31'd0, HALTED}, {31'd0, e_halted});
            chk("BUS_ERR", {31'd0, BUS_ERR}, {31'd0, m_bus_err});
            chk("ILL_OP", {31'd0, ILL_OP}, {31'd0, m_ill_op});
        end
        if (MEM_RD === 1'b1) obs_rd++;
        if (MEM_WR === 1'b1) obs_wr++;
        if (IR_LOAD === 1'b1) obs_irl++;
        if (PC_EN === 1'b1) obs_pcen++;
        if (PC_LOAD === 1'b1) obs_pcl++;
        if (ACC_LOAD === 1'b1) obs_accl++;
        if (HALTED === 1'b1 && halt_at < 0) halt_at = cyc;
        if (BUS_ERR === 1'b1 && berr_at < 0) berr_at = cyc;
    endtask

    task automatic do_reset(input int n, input logic rdy);
        for (int i = 0; i < n; i++) begin
            clr_exp();
            chk_status = (i > 0);
            step(1'b1, rdy, rb());
            m_bus_err = 0;
            m_ill_op  = 0;
        end
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            clr_exp();
            e_state = S_HALT; e_halted = 1;
            step(1'b0, rb(), rb());
        end
    endtask

    // One memory access: ready on wait cycle tw, reset on wait cycle rest_at.
    // res: 0 completed, 1 timed out, 2 aborted by reset
    task automatic access(input logic [2:0] st, input int tw, input int rest_at, output int res);
        res = 0;
        for (int w = 0; w < NEVER; w++) begin
            clr_exp();
            e_state = st;
            if (w == rest_at) begin
                step(1'b1, 1'b0, rb());
                m_bus_err = 0; m_ill_op = 0;
                res = 2;
                return;
            end
            if (w == tw) begin
                chk_addr = 1; e_addr_sel = (st != S_FETCH);
                e_mem_rd = (st != S_WR); e_mem_wr = (st == S_WR);
                e_ir_load = (st == S_FETCH); e_pc_en = (st == S_FETCH);
                e_acc_load = (st == S_RD); e_acc_op = m_acc_op;
                step(1'b0, 1'b1, rb());
                return;
            end
            if (w == WAIT_MAX - 1) begin
                step(1'b0, 1'b0, rb());
                m_bus_err = 1;
                res = 1;
                return;
            end
            chk_addr = 1; e_addr_sel = (st != S_FETCH);
            e_mem_rd = (st != S_WR); e_mem_wr = (st == S_WR);
            step(1'b0, 1'b0, rb());
        end
    endtask

    // res: 0 next instruction, 1 core halted, 2 aborted by reset
    task automatic run_instr(input logic [3:0] opc, input int az_sel, input int tw_f, input int tw_o,
                             input int rest_f, input int rest_o, output int res);
        int   r;
        logic az;
        access(S_FETCH, tw_f, rest_f, r);
        res = r;
        if (r != 0) return;
        cur_opc = opc;
        az = (az_sel < 0) ? rb() : az_sel[0];
        clr_exp();
        e_state = S_DECODE;
        e_pc_load = (opc == OP_JMP) || (opc == OP_JZ && az);
        step(1'b0, rb(), az);
        if (opc == OP_LDA || opc == OP_ADD || opc == OP_SUB || opc == OP_AND) begin
            m_acc_op = (opc == OP_LDA) ? 2'd0 : 2'(opc - 4'd2);
            access(S_RD, tw_o, rest_o, r);
            res = r;
        end else if (opc == OP_STA) begin
            access(S_WR, tw_o, rest_o, r);
            res = r;
        end else if (opc == OP_HLT) begin
            res = 1;
        end else if (opc > OP_HLT) begin
            m_ill_op = 1;
            res = 1;
        end
    endtask

    function automatic int pick_tw();
        int p;
        p = int'($urandom_range(99, 0));
        if (p < 45) return 0;
        if (p < 75) return int'($urandom_range(4, 1));
        if (p < 85) return int'($urandom_range(WAIT_MAX - 2, 5));
        if (p < 92) return WAIT_MAX - 1;
        return NEVER;
    endfunction

    function automatic logic [3:0] pick_op();
        int p;
        p = int'($urandom_range(99, 0));
        if (p < 80) return 4'($urandom_range(7, 0));
        if (p < 88) return OP_HLT;
        return 4'($urandom_range(15, 9));
    endfunction

    initial begin
        int res;
        int rf, ro;
        obs_clear();

        do_reset(2, 1'b1);

        obs_clear();
        run_instr(OP_LDA, -1, 0, 0, -1, -1, res);
        run_instr(OP_ADD, -1, 0, 0, -1, -1, res);
        run_instr(OP_STA, -1, 0, 0, -1, -1, res);
        run_instr(OP_HLT, -1, 0, 0, -1, -1, res);
        halt_cycles(2);
        chk("prog_halt_latency", halt_at - base, 12);
        chk("prog_acc_loads", obs_accl, 2);
        chk("prog_mem_wr_cycles", obs_wr, 1);
        do_reset(2, 1'b1);

        obs_clear();
        run_instr(OP_JZ, 1, 0, 0, -1, -1, res);
        run_instr(OP_JZ, 0, 0, 0, -1, -1, res);
        chk("jz_pc_load_count", obs_pcl, 1);
        chk("jz_pc_en_count", obs_pcen, 2);

        obs_clear();
        run_instr(OP_NOP, -1, 3, 0, -1, -1, res);
        chk("wait3_mem_rd_cycles", obs_rd, 4);
        chk("wait3_ir_load_count", obs_irl, 1);
        chk("wait3_pc_en_count", obs_pcen, 1);

        obs_clear();
        run_instr(OP_NOP, -1, WAIT_MAX - 1, 0, -1, -1, res);
        chk("lastcycle_ready_rd_cycles", obs_rd, WAIT_MAX);
        chk("lastcycle_ready_ir_load", obs_irl, 1);
        chk("lastcycle_ready_no_buserr", berr_at, -1);

        obs_clear();
        run_instr(OP_NOP, -1, NEVER, 0, -1, -1, res);
        halt_cycles(3);
        chk("timeout_rd_cycles", obs_rd, WAIT_MAX - 1);
        chk("timeout_buserr_at", berr_at - base, WAIT_MAX + 1);
        chk("timeout_halt_at", halt_at - base, WAIT_MAX + 1);
        do_reset(2, 1'b0);
        run_instr(OP_NOP, -1, 0, 0, -1, -1, res);

        run_instr(4'hA, -1, 0, 0, -1, -1, res);
        halt_cycles(2);
        do_reset(1, 1'b0);
        obs_clear();
        run_instr(OP_LDA, -1, 0, NEVER, -1, 2, res);
        chk("abort_rd_cycles", obs_rd, 3);
        run_instr(OP_NOP, -1, 0, 0, -1, -1, res);

        for (int n = 0; n < 300; n++) begin
            rf = ($urandom_range(39, 0) == 0) ? int'($urandom_range(3, 0)) : -1;
            ro = ($urandom_range(39, 0) == 0) ? int'($urandom_range(3, 0)) : -1;
            run_instr(pick_op(), -1, pick_tw(), pick_tw(), rf, ro, res);
            if (res == 1) begin
                halt_cycles(int'($urandom_range(3, 1)));
                do_reset(int'($urandom_range(2, 1)), rb());
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
